// File: rtl/sfx_scheduler.sv
// sfx_scheduler
// Shares one tone generator between background music and N_REQ sound-effect
// requesters. While idle the music note passes straight through. A request
// plays that effect's note for len ticks, inserts a short silent gap, and
// then returns to music. A higher requester index wins when several requests
// are pending. Effects are never pre-empted, and requests that arrive
// meanwhile are held as pending.
//
// Ports
//   i_clk          system clock
//   i_reset_n      synchronous active-low reset
//   i_req          per-requester request, sampled every clock
//   i_req_note     note code of requester i at [i*NOTE_W +: NOTE_W]
//   i_req_len      duration in ticks of requester i at [i*LEN_W +: LEN_W]
//   i_music_note   background music note code
//   i_music_valid  music note valid
//   i_mute         forces o_note_en low; scheduling carries on unchanged
//   o_note_out     note code to the tone generator
//   o_note_en      tone generator enable
//   o_grant        one-hot index of the effect being loaded/played, else 0
//   o_busy         high while loading, playing or in the gap
//   o_done         one-cycle pulse in the first cycle after an effect ends
//   o_done_id      index of the finished effect, valid with o_done
module sfx_scheduler #(
  parameter int N_REQ    = 4,
  parameter int NOTE_W   = 6,
  parameter int LEN_W    = 4,
  parameter int TICK_DIV = 4194304,
  parameter int GAP_CYC  = 1024,
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*NOTE_W-1:0] i_req_note,
  input  logic [N_REQ*LEN_W-1:0]  i_req_len,
  input  logic [NOTE_W-1:0]       i_music_note,
  input  logic                    i_music_valid,
  input  logic                    i_mute,
  output logic [NOTE_W-1:0]       o_note_out,
  output logic                    o_note_en,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ID_W-1:0]         o_done_id
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [N_REQ-1:0]    r_pending;
  logic [NOTE_W-1:0]   r_capNote [N_REQ];
  logic [LEN_W-1:0]    r_capLen  [N_REQ];
  logic [ID_W-1:0]     r_grantIdx;
  logic [NOTE_W-1:0]   r_noteReg;
  logic [LEN_W-1:0]    r_remaining;
  logic [PRE_W-1:0]    r_prescale;
  logic [GAP_W-1:0]    r_gapCnt;
  logic                r_done;
  logic [ID_W-1:0]     r_doneId;

  logic [ID_W-1:0]     w_sel;
  logic                w_anyPending;
  logic                w_lastTick;
  logic                w_gapEnd;

  // Highest pending index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_pending[i]) w_sel = ID_W'(i);
    end
  end

  assign w_anyPending = |r_pending;
  assign w_lastTick   = (r_prescale == PRE_LAST) && (r_remaining == LEN_W'(1));
  assign w_gapEnd     = (r_gapCnt == GAP_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_grantIdx  <= '0;
      r_noteReg   <= '0;
      r_remaining <= '0;
      r_prescale  <= '0;
      r_gapCnt    <= '0;
      r_done      <= 1'b0;
      r_doneId    <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_capNote[i] <= '0;
        r_capLen[i]  <= '0;
      end
    end else begin
      r_state <= w_nextState;
      r_done  <= 1'b0;

      // A new request wins over the clear done while loading that index, so
      // a re-trigger during LOAD is queued rather than lost.
      for (int i = 0; i < N_REQ; i++) begin
        if (i_req[i]) begin
          r_pending[i] <= 1'b1;
          r_capNote[i] <= i_req_note[i*NOTE_W +: NOTE_W];
          r_capLen[i]  <= i_req_len[i*LEN_W +: LEN_W];
        end else if ((r_state == S_LOAD) && (w_sel == ID_W'(i))) begin
          r_pending[i] <= 1'b0;
        end
      end

      case (r_state)
        S_LOAD: begin
          r_grantIdx  <= w_sel;
          r_noteReg   <= r_capNote[w_sel];
          // A zero length still plays one tick.
          r_remaining <= (r_capLen[w_sel] == '0) ? LEN_W'(1) : r_capLen[w_sel];
          r_prescale  <= '0;
        end
        S_PLAY: begin
          if (r_prescale == PRE_LAST) begin
            r_prescale  <= '0;
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_done   <= 1'b1;
              r_doneId <= r_grantIdx;
              r_gapCnt <= '0;
            end
          end else begin
            r_prescale <= r_prescale + PRE_W'(1);
          end
        end
        S_GAP: begin
          if (!w_gapEnd) r_gapCnt <= r_gapCnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_anyPending) w_nextState = S_LOAD;
      S_LOAD: w_nextState = S_PLAY;
      S_PLAY: begin
        if (w_lastTick) begin
          if (GAP_CYC > 0)       w_nextState = S_GAP;
          else if (w_anyPending) w_nextState = S_LOAD;
          else                   w_nextState = S_IDLE;
        end
      end
      S_GAP: begin
        if (w_gapEnd) w_nextState = w_anyPending ? S_LOAD : S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Outputs are held at their reset values while reset is asserted, so the
  // tone generator is silenced immediately, even before the first clock edge.
  always_comb begin
    o_note_out = '0;
    o_note_en  = 1'b0;
    o_grant    = '0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_done_id  = '0;
    if (i_reset_n) begin
      o_done    = r_done;
      o_done_id = r_doneId;
      case (r_state)
        S_IDLE: begin
          o_note_out = i_music_note;
          o_note_en  = i_music_valid & ~i_mute;
        end
        S_LOAD: begin
          o_grant = ONE_HOT0 << w_sel;
          o_busy  = 1'b1;
        end
        S_PLAY: begin
          o_note_out = r_noteReg;
          o_note_en  = ~i_mute;
          o_grant    = ONE_HOT0 << r_grantIdx;
          o_busy     = 1'b1;
        end
        S_GAP: o_busy = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler
// Self-checking bench for sfx_scheduler with TICK_DIV=4, GAP_CYC=2, N_REQ=4.
// The single-requester timing is covered by a cycle-by-cycle vector table.
// Priority, queuing during PLAY, and reset abort are covered by short
// sequences that collect play/done statistics.
module tb_sfx_scheduler;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [3:0]  i_req;
  logic [23:0] i_req_note;
  logic [15:0] i_req_len;
  logic [5:0]  i_music_note;
  logic        i_music_valid;
  logic        i_mute;
  logic [5:0]  o_note_out;
  logic        o_note_en;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_done_id;

  int testsRun = 0;
  int testsFailed = 0;

  sfx_scheduler #(
    .N_REQ(4), .NOTE_W(6), .LEN_W(4), .TICK_DIV(4), .GAP_CYC(2)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req),
    .i_req_note(i_req_note), .i_req_len(i_req_len),
    .i_music_note(i_music_note), .i_music_valid(i_music_valid), .i_mute(i_mute),
    .o_note_out(o_note_out), .o_note_en(o_note_en), .o_grant(o_grant),
    .o_busy(o_busy), .o_done(o_done), .o_done_id(o_done_id)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string      tag;
    logic       rstN;
    logic [3:0] req;
    logic [5:0] note;
    logic [3:0] len;
    logic       mute;
    logic       chkNote;
    logic [5:0] expNote;
    logic       expEn;
    logic [3:0] expGrant;
    logic       expBusy;
    logic       expDone;
    logic [1:0] expDoneId;
  } vec_t;

  vec_t vecs[$];

  // Statistics collected by sample() during the multi-cycle sequences.
  logic [5:0] noteOf [4];
  int         playCnt [4];
  int         firstPlay [4];
  int         doneCyc [4];
  logic [1:0] doneQ[$];
  logic       sawBusy;

  task automatic addVec(input int n, input string tag, input logic rstN,
                        input logic [3:0] req, input logic [5:0] note,
                        input logic [3:0] len, input logic mute,
                        input logic chkNote, input logic [5:0] expNote,
                        input logic expEn, input logic [3:0] expGrant,
                        input logic expBusy, input logic expDone,
                        input logic [1:0] expDoneId);
    vec_t v;
    v.tag = tag; v.rstN = rstN; v.req = req; v.note = note; v.len = len;
    v.mute = mute; v.chkNote = chkNote; v.expNote = expNote; v.expEn = expEn;
    v.expGrant = expGrant; v.expBusy = expBusy; v.expDone = expDone;
    v.expDoneId = expDoneId;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge i_clk);
    i_reset_n  = v.rstN;
    i_req      = v.req;
    i_req_note = {4{v.note}};
    i_req_len  = {4{v.len}};
    i_mute     = v.mute;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp, input logic [31:0] mask);
    testsRun++;
    if ((act & mask) !== (exp & mask)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act & mask, exp & mask);
    end
  endtask

  task automatic clearStats();
    for (int i = 0; i < 4; i++) begin
      playCnt[i] = 0;
      firstPlay[i] = -1;
      doneCyc[i] = -1;
    end
    doneQ.delete();
    sawBusy = 1'b0;
  endtask

  task automatic sample(input int c);
    for (int i = 0; i < 4; i++) begin
      if (o_grant[i] && o_note_en && (o_note_out == noteOf[i])) begin
        if (playCnt[i] == 0) firstPlay[i] = c;
        playCnt[i]++;
      end
    end
    if (o_done) begin
      doneQ.push_back(o_done_id);
      doneCyc[o_done_id] = c;
    end
    if (o_busy) sawBusy = 1'b1;
  endtask

  function automatic logic [31:0] doneAt(input int k);
    return (doneQ.size() > k) ? 32'(doneQ[k]) : 32'hFFFF;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit injected;
    logic [31:0] actV, expV, maskV;

    i_reset_n = 1'b0; i_req = '0; i_req_note = '0; i_req_len = '0;
    i_music_note = 6'd42; i_music_valid = 1'b1; i_mute = 1'b0;

    // Reset, then a single req[1] (note 20, len 3), then a muted len=0 req[2].
    addVec(2,  "reset",        0, 4'b0000, 0, 0, 0, 1, 0,  0, 4'b0000, 0, 0, 0);
    addVec(1,  "idle_music",   1, 4'b0000, 0, 0, 0, 1, 42, 1, 4'b0000, 0, 0, 0);
    addVec(1,  "t2_req",       1, 4'b0010, 20, 3, 0, 1, 42, 1, 4'b0000, 0, 0, 0);
    addVec(1,  "t2_idle_pend", 1, 4'b0000, 7, 9, 0, 1, 42, 1, 4'b0000, 0, 0, 0);
    addVec(1,  "t2_load",      1, 4'b0000, 7, 9, 0, 0, 0,  0, 4'b0010, 1, 0, 0);
    addVec(12, "t2_play",      1, 4'b0000, 7, 9, 0, 1, 20, 1, 4'b0010, 1, 0, 0);
    addVec(1,  "t2_gap_done",  1, 4'b0000, 7, 9, 0, 0, 0,  0, 4'b0000, 1, 1, 1);
    addVec(1,  "t2_gap",       1, 4'b0000, 7, 9, 0, 0, 0,  0, 4'b0000, 1, 0, 0);
    addVec(1,  "t2_music",     1, 4'b0000, 7, 9, 0, 1, 42, 1, 4'b0000, 0, 0, 0);
    addVec(1,  "t5_req",       1, 4'b0100, 9, 0, 1, 1, 42, 0, 4'b0000, 0, 0, 0);
    addVec(1,  "t5_idle_pend", 1, 4'b0000, 7, 9, 1, 1, 42, 0, 4'b0000, 0, 0, 0);
    addVec(1,  "t5_load",      1, 4'b0000, 7, 9, 1, 0, 0,  0, 4'b0100, 1, 0, 0);
    addVec(4,  "t5_play",      1, 4'b0000, 7, 9, 1, 1, 9,  0, 4'b0100, 1, 0, 0);
    addVec(1,  "t5_gap_done",  1, 4'b0000, 7, 9, 1, 0, 0,  0, 4'b0000, 1, 1, 2);
    addVec(1,  "t5_gap",       1, 4'b0000, 7, 9, 1, 0, 0,  0, 4'b0000, 1, 0, 0);
    addVec(1,  "t5_idle_mute", 1, 4'b0000, 7, 9, 1, 1, 42, 0, 4'b0000, 0, 0, 0);
    addVec(1,  "t5_unmute",    1, 4'b0000, 7, 9, 0, 1, 42, 1, 4'b0000, 0, 0, 0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      #1;
      actV  = 32'({o_note_out, o_note_en, o_grant, o_busy, o_done, o_done_id});
      expV  = 32'({vecs[k].expNote, vecs[k].expEn, vecs[k].expGrant,
                   vecs[k].expBusy, vecs[k].expDone, vecs[k].expDoneId});
      maskV = 32'({vecs[k].chkNote ? 6'h3F : 6'h00, 7'h7F,
                   vecs[k].expDone ? 2'b11 : 2'b00});
      checkOutput(vecs[k].tag, actV, expV, maskV);
    end

    // Distinct notes per requester for the sequences below.
    noteOf[0] = 6'd5; noteOf[1] = 6'd20; noteOf[2] = 6'd17; noteOf[3] = 6'd33;
    i_req_note = {noteOf[3], noteOf[2], noteOf[1], noteOf[0]};
    i_mute = 1'b0;

    // req[0] and req[3] together: 3 plays first, then 0 after the gap.
    clearStats();
    i_req_len = {4{4'd1}};
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      i_req = (c == 0) ? 4'b1001 : 4'b0000;
      #1;
      sample(c);
    end
    checkOutput("t3_done_count", 32'(doneQ.size()), 32'd2, '1);
    checkOutput("t3_first_done_id", doneAt(0), 32'd3, '1);
    checkOutput("t3_second_done_id", doneAt(1), 32'd0, '1);
    checkOutput("t3_play3_cycles", 32'(playCnt[3]), 32'd4, '1);
    checkOutput("t3_play0_cycles", 32'(playCnt[0]), 32'd4, '1);
    checkOutput("t3_gap_to_next_play", 32'(firstPlay[0] - doneCyc[3]), 32'd3, '1);
    checkOutput("t3_back_idle", 32'(o_busy), 32'd0, '1);

    // req[2] arrives during PLAY of req[0]: no pre-emption, then it follows.
    clearStats();
    injected = 1'b0;
    i_req_len = {4'd1, 4'd1, 4'd1, 4'd2};
    for (int c = 0; c < 50; c++) begin
      @(negedge i_clk);
      i_req = 4'b0000;
      if (c == 0) i_req = 4'b0001;
      else if (!injected && playCnt[0] == 3) begin
        i_req = 4'b0100;
        injected = 1'b1;
      end
      #1;
      sample(c);
    end
    checkOutput("t4_injected_in_play", 32'(injected), 32'd1, '1);
    checkOutput("t4_done_count", 32'(doneQ.size()), 32'd2, '1);
    checkOutput("t4_first_done_id", doneAt(0), 32'd0, '1);
    checkOutput("t4_second_done_id", doneAt(1), 32'd2, '1);
    checkOutput("t4_play0_full_len", 32'(playCnt[0]), 32'd8, '1);
    checkOutput("t4_play2_cycles", 32'(playCnt[2]), 32'd4, '1);
    checkOutput("t4_gap_to_next_play", 32'(firstPlay[2] - doneCyc[0]), 32'd3, '1);
    checkOutput("t4_back_idle", 32'(o_busy), 32'd0, '1);

    // Reset mid-PLAY with req[3] pending: abort, no done, pending dropped.
    clearStats();
    i_req_len = {4{4'd3}};
    for (int c = 0; c < 10 && playCnt[1] < 2; c++) begin
      @(negedge i_clk);
      i_req = 4'b0000;
      if (c == 0) i_req = 4'b0010;
      else if (playCnt[1] == 1) i_req = 4'b1000;
      #1;
      sample(c);
    end
    checkOutput("t6_reached_play", 32'(playCnt[1] >= 2), 32'd1, '1);
    @(negedge i_clk);
    i_req = 4'b0000;
    i_reset_n = 1'b0;
    @(negedge i_clk);
    #1;
    checkOutput("t6_outputs_in_reset",
                32'({o_note_out, o_note_en, o_grant, o_busy, o_done, o_done_id}),
                32'd0, '1);
    clearStats();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      #1;
      sample(c);
    end
    checkOutput("t6_no_done_after_abort", 32'(doneQ.size()), 32'd0, '1);
    checkOutput("t6_pending_cleared", 32'(sawBusy), 32'd0, '1);
    checkOutput("t6_music_back", 32'({o_note_out, o_note_en}), 32'({6'd42, 1'b1}), '1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
